// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and instruction-fetch stage.
// Issues one word read at a time, holds the returned instruction for the
// control decoder, and computes the next PC once the decoder/ALU resolves
// the control outcome of the held instruction.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN adds the fetch_misalign output.
// It sets sticky on a misaligned next PC, and RESET_PC is used instead of
// the bad target.
//
// Handshakes (all completions are suppressed while stall is high):
//   imem:  imem_req stays high from the cycle after FETCH until the cycle in
//          which imem_ready is seen. imem_rdata is captured in that cycle.
//   instr: instr_valid stays high with instr/pc_out stable until
//          instr_ready is seen. The transfer happens in that cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        resolve,
  input  logic        branch_on_eq,
  input  logic        branch_on_neq,
  input  logic        jump,
  input  logic        zero,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_misalign,
`endif
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    ISSUE    = 2'd2,
    RESOLVE  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_MAX4 = 4'(MEM_WAIT_MAX);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [3:0]  wait_cnt;

  // Strobes decoded from the current state and inputs
  logic        capture;
  logic        accept;
  logic        pc_update;
  logic [3:0]  wait_inc;
  logic        wait_expire;

  // Next-PC datapath
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

  // State register; stall freezes the FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
    end else if (!stall) begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FETCH:    state_next = WAIT_MEM;
      WAIT_MEM: if (imem_ready) state_next = ISSUE;
      ISSUE:    if (instr_ready) state_next = resolve ? FETCH : RESOLVE;
      RESOLVE:  if (resolve) state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Output/strobe decode for the registered datapath below
  always_comb begin
    capture     = (state == WAIT_MEM) && imem_ready;
    accept      = (state == ISSUE) && instr_ready;
    pc_update   = (accept && resolve) || ((state == RESOLVE) && resolve);
    wait_inc    = wait_cnt + 4'd1;
    wait_expire = (state == WAIT_MEM) && !imem_ready && (wait_inc == WAIT_MAX4);
  end

  // Next PC: jump beats a taken branch, which beats fall-through
  always_comb begin
    pc4           = pc_out + 32'd4;
    jump_target   = {pc4[31:28], instr[25:0], 2'b00};
    branch_target = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    branch_taken  = (branch_on_eq & zero) | (branch_on_neq & ~zero);
    next_pc       = pc4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Memory side: request, wait counter, timeout pulse, instruction capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_req      <= 1'b0;
      wait_cnt      <= 4'd0;
      fetch_timeout <= 1'b0;
      instr         <= 32'd0;
      pc_out        <= RESET_PC;
    end else if (!stall) begin
      fetch_timeout <= 1'b0;
      if (state == FETCH) begin
        imem_req <= 1'b1;
        wait_cnt <= 4'd0;
      end
      if (capture) begin
        imem_req <= 1'b0;
        instr    <= imem_rdata;
        pc_out   <= pc;
        wait_cnt <= 4'd0;
      end else if (wait_expire) begin
        fetch_timeout <= 1'b1;
        wait_cnt      <= 4'd0;
      end else if (state == WAIT_MEM) begin
        wait_cnt <= wait_inc;
      end
    end
  end

  // Decoder side: valid flag set on capture, cleared on acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (capture) begin
        instr_valid <= 1'b1;
      end else if (accept) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // PC update; a misaligned target restarts at RESET_PC and flags sticky
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc             <= RESET_PC;
      fetch_misalign <= 1'b0;
    end else if (!stall && pc_update) begin
      if (next_pc[1:0] != 2'b00) begin
        pc             <= RESET_PC;
        fetch_misalign <= 1'b1;
      end else begin
        pc <= next_pc;
      end
    end
  end
`else
  // PC update; low bits forced to zero so the PC stays word-aligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (!stall && pc_update) begin
      pc <= next_pc & ~32'd3;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Three instances share all inputs and
// run in lockstep; they differ only in RESET_PC so upper-bit jump and PC
// wrap-around are observable without long branch chains.
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        resolve;
  logic        branch_on_eq;
  logic        branch_on_neq;
  logic        jump;
  logic        zero;

  logic        imem_req,      b_imem_req,      c_imem_req;
  logic [31:0] imem_addr,     b_imem_addr,     c_imem_addr;
  logic [31:0] instr,         b_instr,         c_instr;
  logic [5:0]  opcode,        b_opcode,        c_opcode;
  logic [5:0]  funct,         b_funct,         c_funct;
  logic [31:0] pc_out,        b_pc_out,        c_pc_out;
  logic        instr_valid,   b_instr_valid,   c_instr_valid;
  logic        fetch_timeout, b_fetch_timeout, c_fetch_timeout;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign, b_fetch_misalign, c_fetch_misalign;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WAIT_MAX(15)) u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .resolve(resolve),
    .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq),
    .jump(jump), .zero(zero),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .fetch_timeout(fetch_timeout)
  );

  instr_fetch_unit #(.RESET_PC(32'h1000_0000), .MEM_WAIT_MAX(15)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(b_instr), .opcode(b_opcode), .funct(b_funct), .pc_out(b_pc_out),
    .instr_valid(b_instr_valid), .instr_ready(instr_ready), .resolve(resolve),
    .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq),
    .jump(jump), .zero(zero),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign(b_fetch_misalign),
`endif
    .fetch_timeout(b_fetch_timeout)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MEM_WAIT_MAX(15)) u_dut_c (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(c_imem_req), .imem_addr(c_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(c_instr), .opcode(c_opcode), .funct(c_funct), .pc_out(c_pc_out),
    .instr_valid(c_instr_valid), .instr_ready(instr_ready), .resolve(resolve),
    .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq),
    .jump(jump), .zero(zero),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign(c_fetch_misalign),
`endif
    .fetch_timeout(c_fetch_timeout)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // expected fetch addresses for the main instance
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the main instance to raise imem_req
  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    if (!imem_req) check("wait_req_timeout", 32'(imem_req), 32'd1);
  endtask

  // Serve one fetch; optionally hold a stall over the first ready cycle
  task automatic fetch_word(input logic [31:0] word, input bit stall_first);
    logic [31:0] exp_addr;
    exp_addr = exp_q.pop_front();
    wait_req();
    check("fetch_addr", imem_addr, exp_addr);
    if (stall_first) begin
      stall      = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      check("stall_wait_valid", 32'(instr_valid), 32'd0);
      check("stall_wait_req", 32'(imem_req), 32'd1);
      stall = 1'b0;
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    check("capture_valid", 32'(instr_valid), 32'd1);
    check("capture_instr", instr, word);
    check("capture_pc_out", pc_out, exp_addr);
  endtask

  // Accept and resolve the held instruction in the same cycle
  task automatic retire(input logic j, input logic beq, input logic bne, input logic z);
    jump          = j;
    branch_on_eq  = beq;
    branch_on_neq = bne;
    zero          = z;
    instr_ready   = 1'b1;
    resolve       = 1'b1;
    tick();
    instr_ready   = 1'b0;
    resolve       = 1'b0;
    jump          = 1'b0;
    branch_on_eq  = 1'b0;
    branch_on_neq = 1'b0;
    zero          = 1'b0;
    check("retire_valid_clr", 32'(instr_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int pulse_at;
    logic [31:0] exp_addr;

    rst = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; resolve = 1'b0;
    branch_on_eq = 1'b0; branch_on_neq = 1'b0; jump = 1'b0; zero = 1'b0;

    // Reset values, then addi with imem_ready tied high
    imem_ready = 1'b1;
    imem_rdata = 32'h2001_0005;
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_timeout", 32'(fetch_timeout), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_addr_c", c_imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    rst = 1'b1;
    tick();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'd0);
    check("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c2_valid", 32'(instr_valid), 32'd1);
    check("c2_instr", instr, 32'h2001_0005);
    check("c2_opcode", 32'(opcode), 32'h08);
    check("c2_funct", 32'(funct), 32'h05);
    check("c2_req_drop", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    resolve     = 1'b1;
    tick();
    instr_ready = 1'b0;
    resolve     = 1'b0;
    imem_ready  = 1'b0;
    check("c3_next_addr", imem_addr, 32'd4);
    check("c3_wrap_addr_c", c_imem_addr, 32'd0);
    check("c3_valid_clr", 32'(instr_valid), 32'd0);

    // Fresh reset, then jump with a competing taken branch
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'h0000_0000);
    fetch_word(32'h0800_0040, 1'b0);
    check("jmp_pc_out_b", b_pc_out, 32'h1000_0000);
    retire(1'b1, 1'b1, 1'b0, 1'b1);
    check("jmp_target_b", b_imem_addr, 32'h1000_0100);
    exp_q.push_back(32'h0000_0100);

    // beq taken backwards, with a stalled ready cycle on the fetch
    fetch_word(32'h1022_FFFE, 1'b1);
    retire(1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_00FC);

    // addi, accepted first and resolved two cycles later
    fetch_word(32'h2001_0005, 1'b0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("res_valid_clr", 32'(instr_valid), 32'd0);
    check("res_no_req", 32'(imem_req), 32'd0);
    tick();
    check("res_hold_req", 32'(imem_req), 32'd0);
    check("res_hold_addr", imem_addr, 32'h0000_00FC);
    resolve = 1'b1;
    tick();
    resolve = 1'b0;
    exp_q.push_back(32'h0000_0100);

    // beq not taken
    fetch_word(32'h1022_FFFE, 1'b0);
    retire(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h0000_0104);

    // bne with both flags set, memory late by 20 cycles
    exp_addr = exp_q.pop_front();
    wait_req();
    check("to_addr", imem_addr, exp_addr);
    pulses   = 0;
    pulse_at = 0;
    for (int t = 1; t < 20; t++) begin
      tick();
      if (fetch_timeout) begin
        pulses++;
        pulse_at = t;
      end
    end
    check("to_pulse_count", 32'(pulses), 32'd1);
    check("to_pulse_cycle", 32'(pulse_at), 32'd15);
    check("to_still_waiting", 32'(instr_valid), 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h1422_0010;
    tick();
    imem_ready = 1'b0;
    check("to_valid", 32'(instr_valid), 32'd1);
    check("to_instr", instr, 32'h1422_0010);
    check("to_pulse_gone", 32'(fetch_timeout), 32'd0);
    retire(1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0148);

    // Decoder back-pressure, then stalled handshake
    fetch_word(32'h0800_0010, 1'b0);
    repeat (3) tick();
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_instr", instr, 32'h0800_0010);
    stall       = 1'b1;
    instr_ready = 1'b1;
    resolve     = 1'b1;
    jump        = 1'b1;
    tick(); tick();
    check("st_valid", 32'(instr_valid), 32'd1);
    check("st_instr", instr, 32'h0800_0010);
    check("st_pc_out", pc_out, 32'h0000_0148);
    check("st_addr", imem_addr, 32'h0000_0148);
    stall = 1'b0;
    tick();
    instr_ready = 1'b0;
    resolve     = 1'b0;
    jump        = 1'b0;
    check("st_done_valid", 32'(instr_valid), 32'd0);
    check("st_done_addr", imem_addr, 32'h0000_0040);

    // Reset while waiting on memory at 0x40
    wait_req();
    check("mr_addr", imem_addr, 32'h0000_0040);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_req", 32'(imem_req), 32'd0);
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_addr_reset", imem_addr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("end_misalign", 32'(fetch_misalign), 32'd0);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
